// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin byte arbiter feeding one shared UART serializer
// Optional feature macro UART_TX_ARB_ASCII_EN: accepted byte is offset by 8'd48 before transmit.
module uart_tx_arb #(
    parameter int NREQ   = 4,
    parameter int GAP    = 2,
    parameter int ACK_TO = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [8*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     err
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE, GAP_WAIT} state_t;

    state_t        state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic          found;
    logic [GW-1:0] win;
    logic [GW-1:0] cand;
    logic [7:0]    win_byte;
    logic [7:0]    acc_byte;

    // Rotating priority: the scan starts one past the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = GW'((int'(grant_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_byte = req_data[8*int'(win) +: 8];

`ifdef UART_TX_ARB_ASCII_EN
    assign acc_byte = win_byte + 8'd48;
`else
    assign acc_byte = win_byte;
`endif

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst so no handshake can complete while reset is held.
                if (rst && found && !tx_busy) begin
                    req_ready  = NREQ'(1) << win;
                    tx_data_d  = acc_byte;
                    grant_d    = win;
                    tx_start_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == 8'(ACK_TO - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = GAP_WAIT;
                end
            end
            GAP_WAIT: begin
                // GAP of 0 or 1 both spend a single cycle here.
                if (int'(cnt_q) + 1 >= GAP) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= GW'(NREQ - 1);
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb
module tb_uart_tx_arb;
    localparam int NREQ   = 4;
    localparam int GAP    = 2;
    localparam int ACK_TO = 16;
    localparam int GAPC   = (GAP < 1) ? 1 : GAP;
    localparam int GW     = $clog2(NREQ);
`ifdef UART_TX_ARB_ASCII_EN
    localparam logic [7:0] OFS = 8'd48;
`else
    localparam logic [7:0] OFS = 8'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [GW-1:0]     grant_id;
    logic              err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit ser_auto, ser_pending, ser_fell;
    int ser_left, ser_len_min, ser_len_max;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(NREQ), .GAP(GAP), .ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id), .err(err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        int k;
        for (int i = 1; i <= NREQ; i++) begin
            k = (last + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock; the serializer model answers a tx_start with busy one cycle later.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ser_fell = 1'b0;
        if (ser_left > 0) begin
            ser_left--;
            if (ser_left == 0) begin
                tx_busy  = 1'b0;
                ser_fell = 1'b1;
            end
        end
        if (ser_pending) begin
            tx_busy     = 1'b1;
            ser_left    = int'($urandom_range(ser_len_max, ser_len_min));
            ser_pending = 1'b0;
        end
        if (ser_auto && tx_start === 1'b1) ser_pending = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        tx_busy = 1'b0;
        ser_pending = 1'b0;
        ser_left = 0;
        ser_auto = 1'b1;
        ser_len_min = 10;
        ser_len_max = 10;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '1;
        req_data = {NREQ{8'h5A}};
        tx_busy = 1'b0;
        step();
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (grant_id !== GW'(NREQ - 1)) begin bad++; $display("FAIL reset_grant_id got=%0d exp=%0d", grant_id, NREQ - 1); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_single();
        int s, fall, acc;
        do_reset();
        req_data = $urandom;
        req_data[7:0] = 8'h05;
        req_valid = NREQ'(1);
        #1;
        total++; if (req_ready !== NREQ'(1)) begin bad++; $display("FAIL single_ready got=%b exp=%b", req_ready, NREQ'(1)); end
        step();
        req_valid = '0;
        req_data = $urandom;
        #1;
        s = cyc;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b exp=1", tx_start); end
        total++; if (tx_data !== 8'h05 + OFS) begin bad++; $display("FAIL single_data got=%h exp=%h", tx_data, 8'h05 + OFS); end
        total++; if (grant_id !== GW'(0)) begin bad++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
        step();
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_pulse got=%b exp=0 at cycle %0d", tx_start, cyc - s); end
        fall = -1;
        for (int n = 0; n < 40 && fall < 0; n++) begin
            step();
            if (ser_fell) fall = cyc;
        end
        req_valid = NREQ'(1);
        acc = -1;
        for (int n = 0; n < 20 && acc < 0; n++) begin
            #1;
            if (req_ready !== '0) acc = cyc;
            else step();
        end
        total++; if (acc !== fall + 1 + GAPC) begin bad++; $display("FAIL single_gap accept_cycle got=%0d exp=%0d", acc, fall + 1 + GAPC); end
        step();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int grants, starts, last;
        bit chk_gid;
        do_reset();
        req_valid = '1;
        req_data = $urandom;
        grants = 0;
        starts = 0;
        last = -1;
        chk_gid = 1'b0;
        for (int n = 0; n < 300 && grants < 5; n++) begin
            #1;
            if (tx_start === 1'b1) starts++;
            if (chk_gid) begin
                total++; if (grant_id !== GW'(last)) begin bad++; $display("FAIL rr_grant_id got=%0d exp=%0d", grant_id, last); end
                chk_gid = 1'b0;
            end
            if (req_ready !== '0) begin
                total++; if (req_ready !== NREQ'(1) << exp_order[grants]) begin bad++; $display("FAIL rr_order grant %0d got=%b exp=%0d", grants, req_ready, exp_order[grants]); end
                last = exp_order[grants];
                grants++;
                chk_gid = 1'b1;
            end
            step();
        end
        #1;
        if (tx_start === 1'b1) starts++;
        total++; if (grant_id !== GW'(last)) begin bad++; $display("FAIL rr_grant_id_last got=%0d exp=%0d", grant_id, last); end
        total++; if (grants !== 5) begin bad++; $display("FAIL rr_grants got=%0d exp=5", grants); end
        total++; if (starts !== 5) begin bad++; $display("FAIL rr_starts got=%0d exp=5", starts); end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int s, acc;
        do_reset();
        ser_auto = 1'b0;
        req_valid = NREQ'(2);
        step();
        req_valid = '0;
        #1;
        s = cyc;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL to_start got=%b exp=1", tx_start); end
        for (int n = 0; n < ACK_TO; n++) step();
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b exp=0", err); end
        step();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b exp=1", err); end
        req_valid = NREQ'(1);
        acc = -1;
        for (int n = 0; n < 20 && acc < 0; n++) begin
            #1;
            if (req_ready !== '0) acc = cyc;
            else step();
        end
        total++; if (acc !== s + ACK_TO + 1 + GAPC) begin bad++; $display("FAIL to_idle accept_cycle got=%0d exp=%0d", acc, s + ACK_TO + 1 + GAPC); end
        step();
        req_valid = '0;
        for (int n = 0; n < 30; n++) step();
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        rst = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_clear got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = $urandom;
        req_data[7:0] = 8'hA5;
        req_valid = '1;
        step();
        step();
        step();
        step();
        #1;
        total++; if (tx_data !== 8'hA5 + OFS) begin bad++; $display("FAIL rm_data_before got=%h exp=%h", tx_data, 8'hA5 + OFS); end
        #1;
        rst = 1'b0;
        tx_busy = 1'b0;
        ser_left = 0;
        ser_pending = 1'b0;
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rm_tx_start got=%b exp=0", tx_start); end
        total++; if (req_ready !== '0) begin bad++; $display("FAIL rm_req_ready got=%b exp=0", req_ready); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rm_tx_data got=%h exp=00", tx_data); end
        total++; if (grant_id !== GW'(NREQ - 1)) begin bad++; $display("FAIL rm_grant_id got=%0d exp=%0d", grant_id, NREQ - 1); end
        step();
        #1;
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rm_hold_start got=%b exp=0", tx_start); end
        step();
        rst = 1'b1;
        #1;
        total++; if (req_ready !== NREQ'(1)) begin bad++; $display("FAIL rm_first_ready got=%b exp=%b", req_ready, NREQ'(1)); end
        step();
        req_valid = '0;
        #1;
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL rm_first_start got=%b exp=1", tx_start); end
        total++; if (grant_id !== GW'(0)) begin bad++; $display("FAIL rm_first_grant got=%0d exp=0", grant_id); end
    endtask

    task automatic test_busy_block();
        do_reset();
        ser_auto = 1'b0;
        tx_busy = 1'b1;
        req_valid = NREQ'(2);
        for (int n = 0; n < 5; n++) begin
            #1;
            total++; if (req_ready !== '0) begin bad++; $display("FAIL bb_blocked cycle %0d got=%b exp=0", n, req_ready); end
            step();
        end
        tx_busy = 1'b0;
        #1;
        total++; if (req_ready !== NREQ'(2)) begin bad++; $display("FAIL bb_release got=%b exp=%b", req_ready, NREQ'(2)); end
        step();
        req_valid = '0;
    endtask

    task automatic test_random();
        bit              pend [NREQ];
        logic [7:0]      pbyte [NREQ];
        logic [NREQ-1:0] v, exp_rdy;
        logic [7:0]      exp_data;
        int              last, acc_c, idle_from, w;
        bit              active, have;
        do_reset();
        ser_len_min = 1;
        ser_len_max = 6;
        last = NREQ - 1;
        acc_c = -100;
        idle_from = cyc;
        active = 1'b0;
        have = 1'b0;
        exp_data = '0;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0;
            pbyte[k] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            if (active && ser_fell) begin
                active = 1'b0;
                idle_from = cyc + 1 + GAPC;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(3, 0) == 0) begin
                        pend[k] = 1'b1;
                        pbyte[k] = 8'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    pend[k] = 1'b0;
                end
                v[k] = pend[k];
                req_data[8*k +: 8] = pend[k] ? pbyte[k] : 8'($urandom);
            end
            req_valid = v;
            #1;
            exp_rdy = '0;
            w = -1;
            if (!active && cyc >= idle_from) begin
                w = rr_pick(v, last);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cycle %0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
            total++; if (tx_start !== (cyc == acc_c + 1)) begin bad++; $display("FAIL rnd_start cycle %0d got=%b exp=%b", cyc, tx_start, cyc == acc_c + 1); end
            if (have) begin
                total++; if (tx_data !== exp_data) begin bad++; $display("FAIL rnd_data cycle %0d got=%h exp=%h", cyc, tx_data, exp_data); end
                total++; if (grant_id !== GW'(last)) begin bad++; $display("FAIL rnd_grant cycle %0d got=%0d exp=%0d", cyc, grant_id, last); end
            end
            if (w >= 0) begin
                last = w;
                exp_data = pbyte[w] + OFS;
                pend[w] = 1'b0;
                active = 1'b1;
                have = 1'b1;
                acc_c = cyc;
            end
            step();
        end
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", err); end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        tx_busy = 1'b0;
        ser_auto = 1'b0;
        ser_pending = 1'b0;
        ser_fell = 1'b0;
        ser_left = 0;
        ser_len_min = 10;
        ser_len_max = 10;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_busy_block();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
